// File: rtl/cpu.sv
// cpu: two-cycle (FETCH/EXEC) 8-bit accumulator CPU driving an external 16-word memory.
// Build macro HALT_EN adds a HALT state entered by opcode 1111; without it 1111 is a NOP.
module cpu #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   output logic              read,
   output logic              write,
   input  logic [DATA_W-1:0] memoryOut,
   output logic [DATA_W-1:0] memoryIn,
   output logic [ADDR_W-1:0] address,
   output logic [1:0]        dbg_state_o,
   output logic [ADDR_W-1:0] dbg_pc_o,
   output logic [DATA_W-1:0] dbg_ir_o,
   output logic [DATA_W-1:0] dbg_ac_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1
`ifdef HALT_EN
      , S_HALT = 2'd2
`endif
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_LDA = 4'd4,
      OP_STA = 4'd5,
      OP_JMP = 4'd6,
      OP_JZ  = 4'd7,
      OP_HLT = 4'd15
   } opcode_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] ac_q, ac_d;

   opcode_t           opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_res;
   logic              op_reads;
   logic              op_is_sta;
   logic              take_branch;

   assign opcode  = opcode_t'(ir_q[DATA_W-1 -: 4]);
   assign operand = ir_q[ADDR_W-1:0];

   // Memory strobes: read marks a cycle in which memoryOut is consumed at the next edge;
   // write marks a cycle in which memory captures memoryIn at address on the next edge.
   // The two are mutually exclusive and both are forced low while clr is high.
   assign memoryIn = ac_q;

   always_comb begin
      alu_res   = ac_q;
      op_reads  = 1'b0;
      op_is_sta = 1'b0;
      case (opcode)
         OP_ADD: begin alu_res = ac_q + memoryOut; op_reads = 1'b1; end
         OP_SUB: begin alu_res = ac_q - memoryOut; op_reads = 1'b1; end
         OP_AND: begin alu_res = ac_q & memoryOut; op_reads = 1'b1; end
         OP_OR:  begin alu_res = ac_q | memoryOut; op_reads = 1'b1; end
         OP_LDA: begin alu_res = memoryOut;        op_reads = 1'b1; end
         OP_STA: op_is_sta = 1'b1;
         default: alu_res = ac_q;
      endcase
   end

   assign take_branch = (opcode == OP_JMP) || ((opcode == OP_JZ) && (ac_q == '0));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ac_d    = ac_q;
      read    = 1'b0;
      write   = 1'b0;
      address = '0;
      case (state_q)
         S_FETCH: begin
            address = pc_q;
            read    = 1'b1;
            ir_d    = memoryOut;
            pc_d    = pc_q + 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            address = operand;
            read    = op_reads;
            write   = op_is_sta;
            ac_d    = alu_res;
            state_d = S_FETCH;
            if (take_branch) begin
               pc_d = operand;
            end
`ifdef HALT_EN
            if (opcode == OP_HLT) begin
               state_d = S_HALT;
            end
`endif
         end
`ifdef HALT_EN
         S_HALT: begin
            address = pc_q;
         end
`endif
         default: state_d = S_FETCH;
      endcase
      if (clr) begin
         read    = 1'b0;
         write   = 1'b0;
         address = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         ac_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
      end
   end

   assign dbg_state_o = state_q;
   assign dbg_pc_o    = pc_q;
   assign dbg_ir_o    = ir_q;
   assign dbg_ac_o    = ac_q;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed bench for the accumulator CPU with a behavioural 16-word memory.
// Single-instruction vectors run from a table; multi-cycle corner cases are hand sequences.
module tb_cpu;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic       clk = 1'b0;
   logic       clr;
   logic       load;
   logic       read;
   logic       write;
   logic [7:0] memoryOut;
   logic [7:0] memoryIn;
   logic [3:0] address;
   logic [1:0] dbg_state;
   logic [3:0] dbg_pc;
   logic [7:0] dbg_ir;
   logic [7:0] dbg_ac;

   logic [7:0] mem  [16];
   logic [7:0] prog [16];

   int n_checks = 0;
   int n_err    = 0;
   int wr_cnt   = 0;
   int wr_bad   = 0;

   typedef struct {
      logic [7:0] ac;
      logic [7:0] instr;
      logic [7:0] mval;
      logic       exp_rd;
      logic       exp_wr;
      logic [7:0] exp_ac;
      logic [3:0] exp_pc;
      logic [7:0] exp_m15;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   cpu dut (
      .clk         (clk),
      .clr         (clr),
      .read        (read),
      .write       (write),
      .memoryOut   (memoryOut),
      .memoryIn    (memoryIn),
      .address     (address),
      .dbg_state_o (dbg_state),
      .dbg_pc_o    (dbg_pc),
      .dbg_ir_o    (dbg_ir),
      .dbg_ac_o    (dbg_ac)
   );

   assign memoryOut = mem[address];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) mem[i] <= prog[i];
      end else if (write) begin
         mem[address] <= memoryIn;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   // Loads prog into memory during a two-cycle clr pulse; returns at cycle N0 (first FETCH).
   task automatic reset_run();
      load = 1'b1;
      clr  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      #1;
      check("clr_read",  32'(read),    32'd0);
      check("clr_write", 32'(write),   32'd0);
      check("clr_addr",  32'(address), 32'd0);
      clr = 1'b0;
      #1;
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         if (write === 1'b1) begin
            wr_cnt++;
            if (address !== 4'd4 || memoryIn !== 8'h05) wr_bad++;
         end
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int bad;
      int rd_cnt;
      logic [7:0] ins;

      clr  = 1'b1;
      load = 1'b0;
      clear_prog();

      //                ac     instr  mval   rd    wr    exp_ac exp_pc m15
      vecs[0]  = '{8'hFF, 8'h0F, 8'h02, 1'b1, 1'b0, 8'h01, 4'd2, 8'h02}; // ADD wraps
      vecs[1]  = '{8'h0F, 8'h2F, 8'h3C, 1'b1, 1'b0, 8'h0C, 4'd2, 8'h3C}; // AND
      vecs[2]  = '{8'h0C, 8'h3F, 8'h30, 1'b1, 1'b0, 8'h3C, 4'd2, 8'h30}; // OR
      vecs[3]  = '{8'h3C, 8'h1F, 8'h3D, 1'b1, 1'b0, 8'hFF, 4'd2, 8'h3D}; // SUB borrow
      vecs[4]  = '{8'h12, 8'h4F, 8'hA5, 1'b1, 1'b0, 8'hA5, 4'd2, 8'hA5}; // LDA
      vecs[5]  = '{8'h5A, 8'h5F, 8'h00, 1'b0, 1'b1, 8'h5A, 4'd2, 8'h5A}; // STA
      vecs[6]  = '{8'h07, 8'h60, 8'h11, 1'b0, 1'b0, 8'h07, 4'd0, 8'h11}; // JMP 0
      vecs[7]  = '{8'h00, 8'h79, 8'h22, 1'b0, 1'b0, 8'h00, 4'd9, 8'h22}; // JZ taken
      vecs[8]  = '{8'h01, 8'h79, 8'h22, 1'b0, 1'b0, 8'h01, 4'd2, 8'h22}; // JZ not taken
      vecs[9]  = '{8'h33, 8'h8F, 8'h44, 1'b0, 1'b0, 8'h33, 4'd2, 8'h44}; // NOP 1000
      vecs[10] = '{8'h44, 8'hE5, 8'h55, 1'b0, 1'b0, 8'h44, 4'd2, 8'h55}; // NOP 1110

      // Add program, reset state and write pulse accounting.
      clear_prog();
      prog[0] = 8'h47; prog[1] = 8'h06; prog[2] = 8'h54;
      prog[6] = 8'h02; prog[7] = 8'h03;
      reset_run();
      check("rst_state", 32'(dbg_state), 32'(ST_FETCH));
      check("rst_pc",    32'(dbg_pc),    32'd0);
      check("rst_ac",    32'(dbg_ac),    32'd0);
      check("rst_ir",    32'(dbg_ir),    32'd0);
      check("rst_addr",  32'(address),   32'd0);
      check("rst_read",  32'(read),      32'd1);
      wr_cnt = 0;
      wr_bad = 0;
      cyc(6);
      check("add_m4",    32'(mem[4]),    32'h05);
      check("add_ac",    32'(dbg_ac),    32'h05);
      cyc(24);
      check("add_wr_once", 32'(wr_cnt),  32'd1);
      cyc(50);
      check("add_m4_hold", 32'(mem[4]),  32'h05);
      check("add_wr_cnt",  32'(wr_cnt),  32'd3);
      check("add_wr_bad",  32'(wr_bad),  32'd0);

      // Reset asserted during EXEC of STA suppresses the store.
      reset_run();
      cyc(5);
      check("mid_sta_wr", 32'(write),   32'd1);
      clr = 1'b1;
      #1;
      check("mid_clr_wr",   32'(write),   32'd0);
      check("mid_clr_rd",   32'(read),    32'd0);
      check("mid_clr_addr", 32'(address), 32'd0);
      cyc(1);
      clr = 1'b0;
      #1;
      check("mid_m4",    32'(mem[4]),    32'h00);
      check("mid_pc",    32'(dbg_pc),    32'd0);
      check("mid_ac",    32'(dbg_ac),    32'd0);
      check("mid_state", 32'(dbg_state), 32'(ST_FETCH));
      check("mid_addr",  32'(address),   32'd0);
      check("mid_read",  32'(read),      32'd1);

      // Overflow through a real store.
      clear_prog();
      prog[0] = 8'h4D; prog[1] = 8'h0E; prog[2] = 8'h5C;
      prog[13] = 8'hFF; prog[14] = 8'h02;
      reset_run();
      cyc(6);
      check("ovf_m12", 32'(mem[12]), 32'h01);

      // PC wrap from 15 to 0.
      clear_prog();
      prog[0] = 8'h6F; prog[15] = 8'h80;
      reset_run();
      cyc(2);
      check("wrap_f15_addr",  32'(address),   32'd15);
      check("wrap_f15_state", 32'(dbg_state), 32'(ST_FETCH));
      cyc(2);
      check("wrap_f0_addr",   32'(address),   32'd0);
      check("wrap_f0_read",   32'(read),      32'd1);

      // Single-instruction vectors: M0=LDA 14, M1=instr, M14=ac, M15=mval.
      for (int i = 0; i < NV; i++) begin
         clear_prog();
         ins      = vecs[i].instr;
         prog[0]  = 8'h4E;
         prog[1]  = ins;
         prog[14] = vecs[i].ac;
         prog[15] = vecs[i].mval;
         reset_run();
         cyc(3);
         check($sformatf("vec%0d_ex_state", i), 32'(dbg_state), 32'(ST_EXEC));
         check($sformatf("vec%0d_ex_rd", i),    32'(read),      32'(vecs[i].exp_rd));
         check($sformatf("vec%0d_ex_wr", i),    32'(write),     32'(vecs[i].exp_wr));
         check($sformatf("vec%0d_ex_addr", i),  32'(address),   32'(ins[3:0]));
         if (vecs[i].exp_wr) begin
            check($sformatf("vec%0d_ex_din", i), 32'(memoryIn), 32'(vecs[i].ac));
         end
         cyc(1);
         check($sformatf("vec%0d_ac", i),    32'(dbg_ac),    32'(vecs[i].exp_ac));
         check($sformatf("vec%0d_pc", i),    32'(address),   32'(vecs[i].exp_pc));
         check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(ST_FETCH));
         check($sformatf("vec%0d_m15", i),   32'(mem[15]),   32'(vecs[i].exp_m15));
      end

      // Opcode 1111: halts with HALT_EN, otherwise execution continues.
      clear_prog();
      prog[0] = 8'h47; prog[1] = 8'hF0; prog[7] = 8'h03;
      reset_run();
      cyc(4);
      check("hlt_ac", 32'(dbg_ac), 32'h03);
`ifdef HALT_EN
      check("hlt_state", 32'(dbg_state), 32'(ST_HALT));
      check("hlt_read",  32'(read),      32'd0);
      check("hlt_write", 32'(write),     32'd0);
      check("hlt_addr",  32'(address),   32'd2);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         if (read !== 1'b0 || write !== 1'b0 || dbg_ac !== 8'h03 || address !== 4'd2) bad++;
      end
      check("hlt_hold", 32'(bad), 32'd0);
`else
      check("nohlt_state", 32'(dbg_state), 32'(ST_FETCH));
      check("nohlt_read",  32'(read),      32'd1);
      check("nohlt_addr",  32'(address),   32'd2);
      rd_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (read === 1'b1) rd_cnt++;
         cyc(1);
      end
      check("nohlt_reads", 32'(rd_cnt), 32'd20);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
